// File: rtl/pronoc_pkg.sv
// pronoc_pkg: shared flit/header types, field widths and header packing for endpoint injectors.
package pronoc_pkg;
    localparam int NV      = 2;
    localparam int FPAY    = 32;
    localparam int EAW     = 4;
    localparam int DAW     = 4;
    localparam int DSTPW   = 3;
    localparam int CW      = 1;
    localparam int WEIGHTW = 4;
    localparam int HDR_FLDW     = EAW + DAW + DSTPW + CW + WEIGHTW;
    localparam int HDR_MAX_DATw = FPAY - HDR_FLDW;

    typedef enum logic {IDLE, SEND} inj_state_t;

    // Declared MSB first, so src lands at payload bit 0 and weight on top.
    typedef struct packed {
        logic [WEIGHTW-1:0] weight;
        logic [CW-1:0]      cls;
        logic [DSTPW-1:0]   destport;
        logic [DAW-1:0]     dest;
        logic [EAW-1:0]     src;
    } hdr_flit_t;

    typedef struct packed {
        logic            hdr;
        logic            tail;
        logic [NV-1:0]   vc;
        logic [FPAY-1:0] payload;
    } flit_t;

    function automatic int crdt_w(input int b);
        return $clog2(b + 1);
    endfunction

    function automatic logic [FPAY-1:0] build_hdr(
        input logic [EAW-1:0]          src,
        input logic [DAW-1:0]          dest,
        input logic [DSTPW-1:0]        destport,
        input logic [CW-1:0]           cls,
        input logic [WEIGHTW-1:0]      weight,
        input logic [HDR_MAX_DATw-1:0] data
    );
        hdr_flit_t h;
        h = '{weight: weight, cls: cls, destport: destport, dest: dest, src: src};
        return {data, h};
    endfunction
endpackage

// File: rtl/endp_credit_counter.sv
// endp_credit_counter: per-VC credit tracker, saturating at B with an overflow pulse.
module endp_credit_counter
    import pronoc_pkg::*;
#(
    parameter int B     = 4,
    parameter int CRDTW = crdt_w(B)
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic dec,
    output logic nz,
    output logic ovf
);
    logic [CRDTW-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            cnt <= CRDTW'(B);
        else if (inc && !dec && cnt != CRDTW'(B))
            cnt <= cnt + 1'b1;
        else if (dec && !inc)
            cnt <= cnt - 1'b1;
    end

    assign nz  = cnt != '0;
    assign ovf = inc && !dec && cnt == CRDTW'(B);
endmodule

// File: rtl/endp_flit_injector.sv
// endp_flit_injector: serialises one packet request at a time into credit-gated flits.
module endp_flit_injector
    import pronoc_pkg::*;
#(
    parameter int V        = NV,
    parameter int B        = 4,
    parameter int Fpay     = FPAY,
    parameter int EAw      = EAW,
    parameter int DAw      = DAW,
    parameter int DSTPw    = DSTPW,
    parameter int Cw       = CW,
    parameter int WEIGHTw  = WEIGHTW,
    parameter int PCK_SIZw = 4,
    parameter logic [EAw-1:0] SRC_E_ADDR = '0,
    localparam int Fw = 2 + V + Fpay
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                pck_wr,
    input  logic [V-1:0]        pck_vc,
    input  logic [PCK_SIZw-1:0] pck_size,
    input  logic [DAw-1:0]      pck_dest,
    input  logic [Cw-1:0]       pck_class,
    input  logic [WEIGHTw-1:0]  pck_weight,
    input  logic [DSTPw-1:0]    pck_destport,
    input  logic [63:0]         pck_data,
    output logic [V-1:0]        ready,
    input  logic [V-1:0]        credit_in,
    output logic                flit_wr,
    output logic [Fw-1:0]       flit_out,
    output logic                busy,
    output logic                credit_err
);
    inj_state_t          state, state_nxt;
    logic [V-1:0]        vc_q, vc_nxt, nz, ovf, dec;
    logic [PCK_SIZw-1:0] left_q, left_nxt;
    logic                first_q, first_nxt, wr_nxt, accept, emit;
    logic [Fpay-1:0]     hdr_q, hdr_nxt;
    logic [63:0]         dat_q, dat_nxt;
    logic [Fw-1:0]       flit_nxt;

    for (genvar i = 0; i < V; i++) begin : g_crd
        endp_credit_counter #(.B(B)) u_crd (
            .clk  (clk),
            .reset(reset),
            .inc  (credit_in[i]),
            .dec  (dec[i]),
            .nz   (nz[i]),
            .ovf  (ovf[i])
        );
    end

    assign ready  = (state == IDLE) ? nz : '0;
    assign busy   = state == SEND;
    assign accept = state == IDLE && pck_wr && |(pck_vc & ready);
    assign emit   = state == SEND && |(vc_q & nz);
    assign dec    = emit ? vc_q : '0;

    always_comb begin
        state_nxt = state;
        vc_nxt    = vc_q;
        left_nxt  = left_q;
        first_nxt = first_q;
        hdr_nxt   = hdr_q;
        dat_nxt   = dat_q;
        flit_nxt  = flit_out;
        wr_nxt    = 1'b0;
        if (accept) begin
            state_nxt = SEND;
            vc_nxt    = pck_vc;
            left_nxt  = (pck_size == '0) ? PCK_SIZw'(1) : pck_size;
            first_nxt = 1'b1;
            hdr_nxt   = build_hdr(SRC_E_ADDR, pck_dest, pck_destport, pck_class, pck_weight,
                                  pck_data[HDR_MAX_DATw-1:0]);
            dat_nxt   = pck_data >> HDR_MAX_DATw;
        end else if (emit) begin
            wr_nxt    = 1'b1;
            flit_nxt  = {first_q, left_q == PCK_SIZw'(1), vc_q, first_q ? hdr_q : dat_q[Fpay-1:0]};
            first_nxt = 1'b0;
            dat_nxt   = first_q ? dat_q : dat_q >> Fpay;
            left_nxt  = left_q - 1'b1;
            state_nxt = (left_q == PCK_SIZw'(1)) ? IDLE : SEND;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            vc_q       <= '0;
            left_q     <= '0;
            first_q    <= 1'b0;
            hdr_q      <= '0;
            dat_q      <= '0;
            flit_out   <= '0;
            flit_wr    <= 1'b0;
            credit_err <= 1'b0;
        end else begin
            state      <= state_nxt;
            vc_q       <= vc_nxt;
            left_q     <= left_nxt;
            first_q    <= first_nxt;
            hdr_q      <= hdr_nxt;
            dat_q      <= dat_nxt;
            flit_out   <= flit_nxt;
            flit_wr    <= wr_nxt;
            credit_err <= credit_err | (|ovf);
        end
    end
endmodule

// File: tb/tb_endp_flit_injector.sv
// tb_endp_flit_injector: scoreboard bench for the endpoint flit injector.
module tb_endp_flit_injector;
    logic        clk = 1'b0, reset = 1'b0, pck_wr = 1'b0;
    logic [1:0]  pck_vc = '0, credit_in = '0, ready;
    logic [3:0]  pck_size = '0, pck_dest = 4'd5, pck_weight = 4'd2;
    logic [0:0]  pck_class = 1'b1;
    logic [2:0]  pck_destport = 3'd3;
    logic [63:0] pck_data = 64'h0123_4567_89AB_CDEF;
    logic        flit_wr, busy, credit_err;
    logic [35:0] flit_out;
    // Hand-computed payloads for the fixed data/header fields above.
    logic [31:0] pay [6] = '{32'hCDEF_2B50, 32'h4567_89AB, 32'h0000_0123, 32'h0, 32'h0, 32'h0};
    logic [35:0] exp_q [$];
    int n_cmp = 0, n_bad = 0;

    endp_flit_injector dut (
        .clk(clk), .reset(reset), .pck_wr(pck_wr), .pck_vc(pck_vc), .pck_size(pck_size),
        .pck_dest(pck_dest), .pck_class(pck_class), .pck_weight(pck_weight),
        .pck_destport(pck_destport), .pck_data(pck_data), .ready(ready), .credit_in(credit_in),
        .flit_wr(flit_wr), .flit_out(flit_out), .busy(busy), .credit_err(credit_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset && flit_wr) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_flit: got %0h, expected none", flit_out);
            end else
                chk("flit", 64'(flit_out), 64'(exp_q.pop_front()));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        exp_q.delete();
        tick(2);
        reset = 1'b1;
    endtask

    task automatic send(input logic [1:0] vc, input int size, input bit push);
        int n;
        n = (size < 1) ? 1 : size;
        if (push)
            for (int k = 0; k < n; k++) exp_q.push_back({k == 0, k == n - 1, vc, pay[k]});
        pck_vc   = vc;
        pck_size = 4'(size);
        pck_wr   = 1'b1;
        tick(1);
        pck_wr   = 1'b0;
    endtask

    initial begin
        do_reset();
        chk("rst_flit_wr", 64'(flit_wr), 64'd0);
        chk("rst_flit_out", 64'(flit_out), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_credit_err", 64'(credit_err), 64'd0);
        chk("rst_ready", 64'(ready), 64'd3);

        send(2'b01, 1, 1'b1);
        tick(1);
        chk("s1_flit_wr", 64'(flit_wr), 64'd1);
        chk("s1_ready", 64'(ready), 64'd3);
        chk("s1_busy", 64'(busy), 64'd0);
        tick(1);
        chk("s1_drained", 64'(exp_q.size()), 64'd0);

        do_reset();
        send(2'b01, 4, 1'b1);
        chk("s2_ready_busy", 64'(ready), 64'd0);
        chk("s2_busy", 64'(busy), 64'd1);
        tick(4);
        chk("s2_tail_wr", 64'(flit_wr), 64'd1);
        chk("s2_ready_after", 64'(ready), 64'd2);
        chk("s2_idle", 64'(busy), 64'd0);
        tick(1);
        chk("s2_drained", 64'(exp_q.size()), 64'd0);
        chk("s2_quiet", 64'(flit_wr), 64'd0);

        do_reset();
        send(2'b01, 6, 1'b1);
        tick(5);
        chk("s3_stall_wr", 64'(flit_wr), 64'd0);
        chk("s3_stall_left", 64'(exp_q.size()), 64'd2);
        credit_in = 2'b01;
        tick(1);
        credit_in = 2'b00;
        chk("s3_no_early", 64'(flit_wr), 64'd0);
        tick(1);
        chk("s3_flit5_wr", 64'(flit_wr), 64'd1);
        chk("s3_busy", 64'(busy), 64'd1);
        credit_in = 2'b01;
        tick(1);
        credit_in = 2'b00;
        chk("s3_left1", 64'(exp_q.size()), 64'd1);
        chk("s3_stall2", 64'(flit_wr), 64'd0);
        tick(1);
        chk("s3_tail_wr", 64'(flit_wr), 64'd1);
        chk("s3_done", 64'(busy), 64'd0);
        chk("s3_ready", 64'(ready), 64'd2);
        tick(1);
        chk("s3_drained", 64'(exp_q.size()), 64'd0);

        do_reset();
        send(2'b01, 2, 1'b1);
        credit_in = 2'b01;
        tick(1);
        credit_in = 2'b00;
        chk("s4_no_err_simul", 64'(credit_err), 64'd0);
        tick(2);
        chk("s4_drained", 64'(exp_q.size()), 64'd0);
        credit_in = 2'b01;
        tick(1);
        credit_in = 2'b00;
        chk("s4_no_err_at4", 64'(credit_err), 64'd0);
        credit_in = 2'b01;
        tick(1);
        credit_in = 2'b00;
        chk("s4_err_set", 64'(credit_err), 64'd1);
        chk("s4_ready", 64'(ready), 64'd3);
        send(2'b01, 6, 1'b1);
        tick(6);
        chk("s4_sat_left", 64'(exp_q.size()), 64'd2);
        chk("s4_sat_stall", 64'(flit_wr), 64'd0);
        chk("s4_err_sticky", 64'(credit_err), 64'd1);

        do_reset();
        chk("s5_err_cleared", 64'(credit_err), 64'd0);
        send(2'b01, 4, 1'b1);
        pck_vc   = 2'b10;
        pck_size = 4'd1;
        pck_wr   = 1'b1;
        tick(1);
        pck_wr   = 1'b0;
        tick(3);
        chk("s5_tail_wr", 64'(flit_wr), 64'd1);
        chk("s5_idle", 64'(busy), 64'd0);
        chk("s5_ready", 64'(ready), 64'd2);
        tick(1);
        chk("s5_drained", 64'(exp_q.size()), 64'd0);
        chk("s5_no_extra", 64'(flit_wr), 64'd0);
        send(2'b01, 1, 1'b0);
        chk("s5_nocredit_busy", 64'(busy), 64'd0);
        tick(1);
        chk("s5_nocredit_wr", 64'(flit_wr), 64'd0);

        do_reset();
        send(2'b01, 4, 1'b1);
        tick(2);
        chk("s6_flit2_wr", 64'(flit_wr), 64'd1);
        reset = 1'b0;
        exp_q.delete();
        #1;
        chk("s6_abort_wr", 64'(flit_wr), 64'd0);
        chk("s6_abort_out", 64'(flit_out), 64'd0);
        chk("s6_abort_busy", 64'(busy), 64'd0);
        chk("s6_abort_ready", 64'(ready), 64'd3);
        tick(1);
        reset = 1'b1;
        send(2'b10, 2, 1'b1);
        tick(2);
        chk("s6_new_tail_wr", 64'(flit_wr), 64'd1);
        tick(1);
        chk("s6_drained", 64'(exp_q.size()), 64'd0);
        chk("s6_ready", 64'(ready), 64'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/endp_flit_injector.md
# endp_flit_injector

Endpoint-side packet-to-flit converter sitting directly upstream of a router local input port. It accepts one packet request at a time on the packet injector interface. It serialises the request into header, body and tail flits on a flit channel, and tracks per-VC credits returned by the router so that it never overruns the router input buffer. It is used by traffic generators and NI shims in simulation and synthesis.

## Interface
Parameters:
- V, 2: number of virtual channels.
- B, 4: router input buffer depth per VC; initial credit value.
- Fpay, 32: flit payload width.
- EAw / DAw / DSTPw / Cw / WEIGHTw, 4/4/3/1/4: header field widths, matching the shared package.
- PCK_SIZw, 4: packet size field width (size in flits).
- SRC_E_ADDR, 0: this endpoint's address, placed in the header src field.

Ports:
- clk: in, 1 — clock.
- reset: in, 1 — asynchronous, active-low.
- pck_wr: in, 1 — packet request strobe.
- pck_vc: in, V — target VC, one-hot.
- pck_size: in, PCK_SIZw — packet length in flits.
- pck_dest: in, DAw — destination endpoint address.
- pck_class: in, Cw — message class.
- pck_weight: in, WEIGHTw — initial WRRA weight.
- pck_destport: in, DSTPw — look-ahead destination port from the external routing function, sampled with pck_wr.
- pck_data: in, 64 — packet data.
- ready: out, V — per-VC acceptance.
- credit_in: in, V — one credit returned per asserted bit per cycle.
- flit_wr: out, 1 — flit valid.
- flit_out: out, Fw — {hdr_flag, tail_flag, vc[V], payload[Fpay]}.
- busy: out, 1 — a packet is in flight.
- credit_err: out, 1 — sticky credit-overflow flag.

## Operation
- FSM states: IDLE and SEND.
- ready[v] = (state==IDLE) && credit[v]!=0.
- **Packet acceptance:** pck_wr is accepted only if (pck_wr && |(pck_vc & ready)). On acceptance, all fields are latched, flits_left = max(pck_size,1), and the FSM goes to SEND.
- **pck_wr while not ready:** ignored, no side effect.
- **Flit emission in SEND:** a flit is emitted in any cycle where credit[vc]!=0. Otherwise the block stalls; flit_wr stays 0 and flit_out holds its value.
- **Header flit:** hdr_flag=1. The payload LSBs carry src, dest, destport, class, weight in that order from bit 0 up. The upper HDR_MAX_DATw bits carry pck_data[HDR_MAX_DATw-1:0].
- **Body/tail flit k (k≥1):** payload = pck_data >> (HDR_MAX_DATw+(k-1)·Fpay), truncated to Fpay and zero-filled beyond bit 63.
- **Tail flag:** tail_flag=1 on the last flit. A size-1 packet produces a single flit with hdr=tail=1.
- **Packet completion:** after the tail flit the FSM returns to IDLE. ready can rise in the cycle after the tail flit.
- **Credits:** credit[v] decrements on each emitted flit for v and increments on credit_in[v]. A simultaneous decrement and increment leaves it unchanged.
- **Credit overflow:** an increment at credit[v]==B saturates the counter and sets credit_err. credit_err clears only on reset.
- **Credit counter width:** log2(B+1).

## Timing
- Outputs are registered.
- pck_wr accepted at edge t → header flit_wr=1 at t+1 (given credit).
- Throughput: one flit per cycle.
- Credit returned at edge t is usable at t+1.
- Reset values: state=IDLE, credit[*]=B, flit_wr=0, flit_out=0, busy=0, credit_err=0, ready=all-ones.
- Reset asserted mid-packet aborts the packet: no tail is sent and credits reload to B.

## Structure
- flit_t, hdr_flit_t, HDR_MAX_DATw and the CRDTw rule belong in pronoc_pkg.
- The field-packing function (header build) also lives in the package.
- The per-VC credit counter is a natural sub-module, endp_credit_counter, instantiated V times.

## Test plan
- **Single-flit packet:** V=2, B=4, size=1, vc=01, dest=5 → one flit with hdr=tail=1, vc=01, dest field=5; credit[0]=3; ready=11 next cycle.
- **Four-flit packet:** size=4, no credit return → flits hdr, body, body, tail on consecutive cycles; credit[0]=0; ready[0]=0, ready[1]=0 (busy), then ready=10 after the tail.
- **Credit stall:** size=6 with B=4 → 4 flits, stall; credit_in[0] pulses at cycles 8 and 10 → flits 5 and 6 emitted the following cycles; tail on flit 6.
- **Simultaneous events:** a flit is emitted on vc0 while credit_in[0]=1 in the same cycle → credit[0] unchanged; credit_in[0] at credit=4 → credit_err=1 and credit stays 4.
- **Refused request:** pck_wr while busy → ignored; the current packet completes unaltered and no extra flits appear.
- **Reset mid-packet:** reset low during flit 2 of 4 → flit_wr=0 immediately, credits=4, state IDLE; a new packet after release starts with a header flit.
